// File: rtl/video_line_fetch.sv
// Line fetcher between the video timing generator and the HDMI TX: requests one
// frame-buffer line per credit and pops the pixel FIFO in step with display enable.
module video_line_fetch #(
  parameter int                H_ACT       = 1920,
  parameter int                V_ACT       = 1080,
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                LINE_STRIDE = 3840,
  parameter int                PREFETCH    = 2,
  parameter logic [DATA_W-1:0] UFLOW_PIX   = 16'hF800
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              vs_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic              de_re_in,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [11:0]       rd_len,
  output logic              fifo_clr,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              vs_o,
  output logic              hs_o,
  output logic              de_o,
  output logic [DATA_W-1:0] pix_o,
  output logic              uflow_o
);

  localparam int CNT_W    = $clog2(V_ACT + 1);
  localparam int SUM_W    = CNT_W + 1;
  localparam int PF_LINES = (PREFETCH > V_ACT) ? V_ACT : PREFETCH;

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]    credit_q, credit_d;
  logic                fs_pend_q, fs_pend_d;
  logic                fifo_clr_q, fifo_clr_d;
  logic                uflow_q, uflow_d;
  logic                uflow_pend_q, uflow_pend_d;
  logic                vs_q, vs_d;
  logic                hs_q, hs_d;
  logic                de_q, de_d;
  logic [DATA_W-1:0]   pix_q, pix_d;
  logic                fs;
  logic                line_done;
  logic                credit_inc;

  always_comb begin
    fs         = vs_in & ~vs_q;
    line_done  = de_q & ~de_in;
    // Outstanding credit plus issued lines never exceeds the frame height.
    credit_inc = line_done &&
                 ((SUM_W'(credit_q) + SUM_W'(req_cnt_q)) < SUM_W'(V_ACT));

    state_d   = state_q;
    rd_req_d  = rd_req_q;
    rd_addr_d = rd_addr_q;
    req_cnt_d = req_cnt_q;
    fs_pend_d = fs_pend_q;
    credit_d  = credit_inc ? credit_q + 1'b1 : credit_q;

    case (state_q)
      IDLE: begin
        if (fs) begin
          credit_d  = CNT_W'(PF_LINES);
          req_cnt_d = '0;
        end else if (credit_q != '0 && req_cnt_q < CNT_W'(V_ACT)) begin
          state_d   = REQ;
          rd_req_d  = 1'b1;
          rd_addr_d = BASE_ADDR + ADDR_W'(req_cnt_q) * ADDR_W'(LINE_STRIDE);
        end
      end
      REQ: begin
        if (rd_ack) begin
          state_d  = IDLE;
          rd_req_d = 1'b0;
          // A frame start seen during the handshake restarts the frame only now.
          if (fs || fs_pend_q) begin
            credit_d  = CNT_W'(PF_LINES);
            req_cnt_d = '0;
            fs_pend_d = 1'b0;
          end else begin
            credit_d  = credit_inc ? credit_q : credit_q - 1'b1;
            req_cnt_d = req_cnt_q + 1'b1;
          end
        end else if (fs) begin
          fs_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vs_d         = vs_in;
    hs_d         = hs_in;
    de_d         = de_in;
    fifo_clr_d   = fs;
    uflow_pend_d = de_re_in & fifo_empty;
    uflow_d      = fs ? 1'b0 : uflow_q;
    if (de_re_in && fifo_empty) uflow_d = 1'b1;
    pix_d        = de_in ? (uflow_pend_q ? UFLOW_PIX : fifo_dout) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= BASE_ADDR;
      req_cnt_q    <= '0;
      credit_q     <= '0;
      fs_pend_q    <= 1'b0;
      fifo_clr_q   <= 1'b0;
      uflow_q      <= 1'b0;
      uflow_pend_q <= 1'b0;
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      req_cnt_q    <= req_cnt_d;
      credit_q     <= credit_d;
      fs_pend_q    <= fs_pend_d;
      fifo_clr_q   <= fifo_clr_d;
      uflow_q      <= uflow_d;
      uflow_pend_q <= uflow_pend_d;
      vs_q         <= vs_d;
      hs_q         <= hs_d;
      de_q         <= de_d;
      pix_q        <= pix_d;
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign rd_len     = 12'(H_ACT);
  assign fifo_clr   = fifo_clr_q;
  assign fifo_rd_en = rstn & de_re_in & ~fifo_empty;
  assign vs_o       = vs_q;
  assign hs_o       = hs_q;
  assign de_o       = de_q;
  assign pix_o      = pix_q;
  assign uflow_o    = uflow_q;

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch: a frame-level reference model checked every
// cycle, plus literal expectations for request addresses and pixel sequences.
module tb_video_line_fetch;
  localparam int          STRIDE = 3840;
  localparam logic [15:0] UF     = 16'hF800;

  logic        clk = 1'b0;
  logic        rstn, vs_in, hs_in, de_in, de_re_in;
  logic        rd_req, rd_ack;
  logic [27:0] rd_addr;
  logic [11:0] rd_len;
  logic        fifo_clr, fifo_rd_en, fifo_empty;
  logic [15:0] fifo_dout = '0;
  logic        vs_o, hs_o, de_o, uflow_o;
  logic [15:0] pix_o;

  always #5 clk = ~clk;

  video_line_fetch #(.H_ACT(8), .V_ACT(4), .PREFETCH(2)) dut (
    .clk(clk), .rstn(rstn), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
    .de_re_in(de_re_in), .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr),
    .rd_len(rd_len), .fifo_clr(fifo_clr), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .vs_o(vs_o), .hs_o(hs_o),
    .de_o(de_o), .pix_o(pix_o), .uflow_o(uflow_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel FIFO emulation: one-cycle read latency, reloaded per line.
  logic [15:0] mem [0:15];
  int          rp = 0;
  int          lvl = 0;
  int          load_n = 0;
  logic        force_empty = 1'b0;
  logic        tb_load = 1'b0;
  assign fifo_empty = force_empty || (lvl == 0);

  always @(posedge clk) begin
    if (tb_load) begin
      rp  <= 0;
      lvl <= load_n;
    end else if (fifo_rd_en && lvl != 0) begin
      fifo_dout <= mem[rp[3:0]];
      rp        <= rp + 1;
      lvl       <= lvl - 1;
    end
  end

  // Read engine: acks a held request after ack_delay cycles.
  int ack_delay = 0;
  int wait_cnt = 0;
  initial begin
    rd_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_ack = 1'b0;
      if (rd_req && rstn) begin
        if (wait_cnt >= ack_delay) begin
          rd_ack   = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Frame-level reference model, updated from pre-edge inputs.
  logic        m_valid = 1'b0;
  logic        m_vs, m_hs, m_de, m_clr, m_uflow, m_rst, m_req_k, m_req, m_prev_vs, m_pend;
  logic [15:0] m_pix, m_st1;
  int          m_line;
  logic [27:0] req_log [$];

  always @(posedge clk) begin
    logic m_fs;
    m_valid = 1'b1;
    if (!rstn) begin
      m_vs = 0; m_hs = 0; m_de = 0; m_clr = 0; m_uflow = 0; m_pix = 0; m_st1 = 0;
      m_rst = 1; m_req_k = 1; m_req = 0; m_line = 0; m_pend = 0; m_prev_vs = 0;
    end else begin
      m_fs      = vs_in && !m_prev_vs;
      m_prev_vs = vs_in;
      m_rst     = 0;
      m_vs      = vs_in;
      m_hs      = hs_in;
      m_de      = de_in;
      m_clr     = m_fs;
      m_pix     = de_in ? m_st1 : 16'h0;
      m_st1     = !de_re_in ? 16'h0 : (fifo_empty ? UF : mem[rp[3:0]]);
      if (m_fs) m_uflow = 0;
      if (de_re_in && fifo_empty) m_uflow = 1;
      if (rd_req && rd_ack) begin
        req_log.push_back(rd_addr);
        m_req_k = 1;
        m_req   = 0;
        if (m_fs || m_pend) begin
          m_line = 0;
          m_pend = 0;
        end else begin
          m_line++;
        end
      end else begin
        m_req_k = rd_req;
        m_req   = rd_req;
        if (m_fs) begin
          if (rd_req) m_pend = 1;
          else m_line = 0;
        end
      end
    end
  end

  logic [15:0] pix_cap [$];
  int          rden_cnt = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("vs_o", vs_o, m_vs);
      check("hs_o", hs_o, m_hs);
      check("de_o", de_o, m_de);
      check("fifo_clr", fifo_clr, m_clr);
      check("uflow_o", uflow_o, m_uflow);
      check("pix_o", pix_o, m_pix);
      check("fifo_rd_en", fifo_rd_en, rstn && de_re_in && !fifo_empty);
      if (m_req_k) check("rd_req", rd_req, m_req);
      if (m_rst) check("rd_addr_rst", rd_addr, 0);
      else if (rd_req) begin
        check("rd_addr", rd_addr, m_line * STRIDE);
        check("rd_len", rd_len, 8);
      end
      if (de_o) pix_cap.push_back(pix_o);
      if (fifo_rd_en) rden_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1; step(2);
    vs_in = 1'b0; step(2);
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (req_log.size() < n && c < budget) begin
      step(1);
      c++;
    end
    check("req_log_count", req_log.size(), n);
  endtask

  task automatic wait_req(input int budget);
    int c = 0;
    while (!rd_req && c < budget) begin
      step(1);
      c++;
    end
    check("wait_rd_req", rd_req, 1);
  endtask

  task automatic load_line();
    for (int i = 0; i < 8; i++) mem[i] = 16'(i + 1);
    load_n  = 8;
    tb_load = 1'b1; step(1);
    tb_load = 1'b0; step(1);
  endtask

  task automatic run_line(input int uf_at);
    hs_in = 1'b1; step(2);
    hs_in = 1'b0; step(2);
    for (int i = 0; i < 9; i++) begin
      de_re_in    = (i < 8);
      de_in       = (i >= 1);
      force_empty = (i == uf_at);
      step(1);
    end
    de_in = 1'b0; de_re_in = 1'b0; force_empty = 1'b0;
    step(4);
  endtask

  logic [15:0] exp_clean [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
  logic [15:0] exp_uf    [8] = '{16'd1, 16'd2, 16'hF800, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};

  initial begin
    int b;
    int r;
    rstn = 1'b0; vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; de_re_in = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    step(3);
    check("rst_rd_req", rd_req, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_pix_uflow", {pix_o, uflow_o}, 0);
    rstn = 1'b1;
    step(3);

    // Frame start: prefetch two lines.
    vs_pulse();
    wait_log(2, 100);
    step(10);
    check("t1_req_count", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      check("t1_addr0", req_log[0], 0);
      check("t1_addr1", req_log[1], 3840);
    end
    check("t1_rd_len", rd_len, 8);

    // Line 1: clean pixels 1..8.
    load_line();
    b = pix_cap.size();
    r = rden_cnt;
    run_line(-1);
    check("t3_pix_count", pix_cap.size() - b, 8);
    check("t3_rden_count", rden_cnt - r, 8);
    if (pix_cap.size() >= b + 8)
      for (int i = 0; i < 8; i++) check("t3_pix_seq", pix_cap[b + i], exp_clean[i]);

    // Line 2: FIFO empty on the third pixel.
    load_line();
    b = pix_cap.size();
    run_line(2);
    check("t4_pix_count", pix_cap.size() - b, 8);
    if (pix_cap.size() >= b + 8)
      for (int i = 0; i < 8; i++) check("t4_pix_seq", pix_cap[b + i], exp_uf[i]);
    check("t4_uflow_set", uflow_o, 1);

    load_line();
    run_line(-1);
    load_line();
    run_line(-1);
    step(10);
    check("t2_req_count", req_log.size(), 4);
    if (req_log.size() >= 4) begin
      check("t2_addr2", req_log[2], 7680);
      check("t2_addr3", req_log[3], 11520);
    end
    check("t4_uflow_sticky", uflow_o, 1);

    // Frame start during a slow handshake.
    b = req_log.size();
    ack_delay = 20;
    vs_pulse();
    check("t4_uflow_cleared", uflow_o, 0);
    wait_req(50);
    step(5);
    vs_in = 1'b1; step(2);
    vs_in = 1'b0;
    check("t5_req_held", rd_req, 1);
    wait_log(b + 2, 300);
    if (req_log.size() >= b + 2) begin
      check("t5_addr_first", req_log[b], 0);
      check("t5_addr_restart", req_log[b + 1], 0);
    end

    // Reset in the middle of a request.
    ack_delay = 1000;
    wait_req(50);
    check("t6_addr_before", rd_addr, 3840);
    step(2);
    rstn = 1'b0;
    step(1);
    check("t6_rd_req", rd_req, 0);
    check("t6_rd_addr", rd_addr, 0);
    check("t6_outs", {vs_o, hs_o, de_o, fifo_clr, fifo_rd_en, uflow_o, pix_o}, 0);
    step(2);
    rstn = 1'b1;
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
